// File: rtl/bch_err_correct_decision_pkg.sv
// Shared definitions for the BCH error-correction decision stage and the Chien search.
// The bit-length helper sizes the root-count/degree fields identically in both stages.
package bch_err_correct_decision_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of bits needed to hold v (at least 1).
    function automatic int bit_len(input int v);
        int n;
        n = 1;
        for (int i = 0; i < 31; i++) begin
            if ((v >> i) != 0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/bch_err_correct_decision.sv
// Flips the received bits flagged by the Chien search, forwards the corrected chunks
// and issues one success/failure decision per frame.
module bch_err_correct_decision
    import bch_err_correct_decision_pkg::*;
#(
    parameter  int PARALLELISM   = 4,
    parameter  int EQUATION_POW  = 3,
    parameter  int CHUNK_NUM     = 256,
    localparam int CNT_LEN       = bit_len(EQUATION_POW),
    localparam int CHUNK_CNT_LEN = (CHUNK_NUM > 1) ? $clog2(CHUNK_NUM) : 1
) (
    input  logic                   clk,
    input  logic                   in_ctr_Arst_n,
    input  logic                   in_ctr_en,
    input  logic                   in_ctr_init,
    input  logic                   in_ctr_done,
    input  logic [CNT_LEN-1:0]     in_degree,
    input  logic [PARALLELISM-1:0] in_data,
    input  logic [PARALLELISM-1:0] in_equal,
    input  logic [CNT_LEN-1:0]     in_errCnt,
    output logic [PARALLELISM-1:0] out_data,
    output logic                   out_data_valid,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   out_dec_valid,
    output logic                   out_dec_success,
    output logic [CNT_LEN-1:0]     out_dec_errCnt,
    output logic                   out_frame_err,
    output logic                   out_abort
);

    localparam logic [CHUNK_CNT_LEN-1:0] LP_LAST = CHUNK_CNT_LEN'(CHUNK_NUM - 1);
    localparam logic [CNT_LEN:0]         LP_MAX  = (CNT_LEN + 1)'(EQUATION_POW);

    state_t                   r_state;
    logic [CHUNK_CNT_LEN-1:0] r_chunk_cnt;
    logic                     r_ovf;
    logic [CNT_LEN-1:0]       r_degree;

    logic                     w_start;
    logic                     w_take;
    logic                     w_done;
    logic                     w_abort;
    logic [CHUNK_CNT_LEN-1:0] w_idx;
    logic                     w_ovf;
    logic [CNT_LEN-1:0]       w_deg;
    logic                     w_frame_err;
    logic                     w_success;

    assign w_start = in_ctr_en & in_ctr_init;
    assign w_take  = w_start | (in_ctr_en & (r_state == RUN));
    assign w_done  = w_take & in_ctr_done;
    assign w_abort = w_start & (r_state == RUN);

    // r_ovf remembers that the counter saturated, so overlong frames are never
    // mistaken for correctly sized ones.
    assign w_idx = w_start ? '0 :
                   (r_chunk_cnt == LP_LAST) ? r_chunk_cnt : r_chunk_cnt + 1'b1;
    assign w_ovf = w_start ? 1'b0 : (r_ovf | (r_chunk_cnt == LP_LAST));
    assign w_deg = w_start ? in_degree : r_degree;

    assign w_frame_err = w_ovf | (w_idx != LP_LAST);
    assign w_success   = ~w_frame_err & ({1'b0, w_deg} <= LP_MAX) & (in_errCnt == w_deg);

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            r_state         <= IDLE;
            r_chunk_cnt     <= '0;
            r_ovf           <= 1'b0;
            r_degree        <= '0;
            out_data        <= '0;
            out_data_valid  <= 1'b0;
            out_first       <= 1'b0;
            out_last        <= 1'b0;
            out_dec_valid   <= 1'b0;
            out_dec_success <= 1'b0;
            out_dec_errCnt  <= '0;
            out_frame_err   <= 1'b0;
            out_abort       <= 1'b0;
        end else begin
            out_data_valid <= w_take;
            out_first      <= w_start;
            out_last       <= w_done;
            out_dec_valid  <= w_done;
            out_abort      <= w_abort;
            if (w_take) begin
                out_data    <= in_data ^ in_equal;
                r_chunk_cnt <= w_idx;
                r_ovf       <= w_ovf;
                r_degree    <= w_deg;
                r_state     <= in_ctr_done ? IDLE : RUN;
            end
            if (w_done) begin
                out_dec_success <= w_success;
                out_dec_errCnt  <= in_errCnt;
                out_frame_err   <= w_frame_err;
            end
        end
    end

endmodule

// File: tb/tb_bch_err_correct_decision.sv
// Directed test of the BCH correction/decision stage with a 4-chunk frame.
module tb_bch_err_correct_decision;

    logic       clk;
    logic       rst_n;
    logic       en, init, done;
    logic [1:0] degree, err_cnt;
    logic [3:0] data, equal;
    logic [3:0] out_data;
    logic       out_data_valid, out_first, out_last, out_dec_valid;
    logic       out_dec_success, out_frame_err, out_abort;
    logic [1:0] out_dec_errCnt;

    int n_checks = 0;
    int n_errors = 0;

    bch_err_correct_decision #(
        .PARALLELISM (4),
        .EQUATION_POW(3),
        .CHUNK_NUM   (4)
    ) dut (
        .clk            (clk),
        .in_ctr_Arst_n  (rst_n),
        .in_ctr_en      (en),
        .in_ctr_init    (init),
        .in_ctr_done    (done),
        .in_degree      (degree),
        .in_data        (data),
        .in_equal       (equal),
        .in_errCnt      (err_cnt),
        .out_data       (out_data),
        .out_data_valid (out_data_valid),
        .out_first      (out_first),
        .out_last       (out_last),
        .out_dec_valid  (out_dec_valid),
        .out_dec_success(out_dec_success),
        .out_dec_errCnt (out_dec_errCnt),
        .out_frame_err  (out_frame_err),
        .out_abort      (out_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one cycle of inputs and returns 1 time unit after the capturing edge.
    task automatic chunk(input logic e, input logic i, input logic d, input logic [1:0] deg,
                         input logic [3:0] dat, input logic [3:0] eq, input logic [1:0] ec);
        en = e; init = i; done = d; degree = deg; data = dat; equal = eq; err_cnt = ec;
        @(posedge clk);
        #1;
        $display("t=%0t en=%b init=%b done=%b in=%h eq=%h -> data=%h v=%b f=%b l=%b dv=%b ok=%b ec=%0d fe=%b ab=%b",
                 $time, e, i, d, dat, eq, out_data, out_data_valid, out_first, out_last,
                 out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err, out_abort);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en = 0; init = 0; done = 0; degree = 0; data = 0; equal = 0; err_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({out_data, out_data_valid, out_first, out_last, out_dec_valid, out_dec_success,
             out_dec_errCnt, out_frame_err, out_abort} !== 14'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got data=%h v=%b dv=%b ok=%b ec=%0d fe=%b ab=%b, required all 0",
                     out_data, out_data_valid, out_dec_valid, out_dec_success, out_dec_errCnt,
                     out_frame_err, out_abort);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_success();
        chunk(1, 1, 0, 2'd2, 4'hA, 4'h0, 2'd0);
        n_checks++;
        if ({out_data, out_data_valid, out_first, out_last} !== {4'hA, 3'b110}) begin
            n_errors++;
            $display("FAIL succ_c0: got data=%h v=%b f=%b l=%b, required A 1 1 0",
                     out_data, out_data_valid, out_first, out_last);
        end
        chunk(1, 0, 0, 2'd0, 4'h3, 4'h1, 2'd0);
        n_checks++;
        if ({out_data, out_data_valid, out_first} !== {4'h2, 2'b10}) begin
            n_errors++;
            $display("FAIL succ_c1_flip: got data=%h v=%b f=%b, required 2 1 0",
                     out_data, out_data_valid, out_first);
        end
        chunk(1, 0, 0, 2'd0, 4'h5, 4'h0, 2'd0);
        n_checks++;
        if (out_data !== 4'h5 || out_dec_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL succ_c2: got data=%h dv=%b, required 5 0", out_data, out_dec_valid);
        end
        chunk(1, 0, 1, 2'd0, 4'hF, 4'h4, 2'd2);
        n_checks++;
        if ({out_data, out_last, out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err}
                !== {4'hB, 3'b111, 2'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL succ_decision: got data=%h l=%b dv=%b ok=%b ec=%0d fe=%b, required B 1 1 1 2 0",
                     out_data, out_last, out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err);
        end
        chunk(1, 0, 0, 2'd0, 4'h6, 4'h6, 2'd0);
        n_checks++;
        if ({out_data, out_data_valid, out_dec_valid, out_dec_success, out_dec_errCnt}
                !== {4'hB, 3'b001, 2'd2}) begin
            n_errors++;
            $display("FAIL succ_idle_hold: got data=%h v=%b dv=%b ok=%b ec=%0d, required B 0 0 1 2",
                     out_data, out_data_valid, out_dec_valid, out_dec_success, out_dec_errCnt);
        end
    endtask

    task automatic test_degree_mismatch();
        chunk(1, 1, 0, 2'd3, 4'h0, 4'h8, 2'd0);
        n_checks++;
        if (out_data !== 4'h8) begin
            n_errors++;
            $display("FAIL deg_c0_flip: got %h, required 8", out_data);
        end
        chunk(1, 0, 0, 2'd0, 4'h7, 4'h0, 2'd0);
        chunk(1, 0, 0, 2'd0, 4'h7, 4'h0, 2'd0);
        chunk(1, 0, 1, 2'd0, 4'h1, 4'h1, 2'd2);
        n_checks++;
        if ({out_data, out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err}
                !== {4'h0, 2'b10, 2'd2, 1'b0}) begin
            n_errors++;
            $display("FAIL deg_decision: got data=%h dv=%b ok=%b ec=%0d fe=%b, required 0 1 0 2 0",
                     out_data, out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err);
        end
    endtask

    task automatic test_short_frame();
        chunk(1, 1, 0, 2'd1, 4'h1, 4'h0, 2'd0);
        chunk(1, 0, 0, 2'd0, 4'h2, 4'h0, 2'd0);
        chunk(1, 0, 1, 2'd0, 4'h3, 4'h0, 2'd1);
        n_checks++;
        if ({out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err} !== {2'b10, 2'd1, 1'b1}) begin
            n_errors++;
            $display("FAIL short_frame: got dv=%b ok=%b ec=%0d fe=%b, required 1 0 1 1",
                     out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err);
        end
    endtask

    task automatic test_long_frame();
        chunk(1, 1, 0, 2'd0, 4'h1, 4'h0, 2'd0);
        for (int k = 0; k < 4; k++) chunk(1, 0, 0, 2'd0, 4'h2, 4'h0, 2'd0);
        chunk(1, 0, 1, 2'd0, 4'h9, 4'h0, 2'd0);
        n_checks++;
        if ({out_data, out_data_valid, out_dec_valid, out_dec_success, out_frame_err}
                !== {4'h9, 4'b1101}) begin
            n_errors++;
            $display("FAIL long_frame: got data=%h v=%b dv=%b ok=%b fe=%b, required 9 1 1 0 1",
                     out_data, out_data_valid, out_dec_valid, out_dec_success, out_frame_err);
        end
    endtask

    task automatic test_abort();
        chunk(1, 1, 0, 2'd2, 4'h1, 4'h0, 2'd0);
        chunk(1, 0, 0, 2'd0, 4'h2, 4'h0, 2'd0);
        chunk(1, 1, 0, 2'd1, 4'h3, 4'h0, 2'd0);
        n_checks++;
        if ({out_data, out_abort, out_first, out_dec_valid} !== {4'h3, 3'b110}) begin
            n_errors++;
            $display("FAIL abort_pulse: got data=%h ab=%b f=%b dv=%b, required 3 1 1 0",
                     out_data, out_abort, out_first, out_dec_valid);
        end
        chunk(1, 0, 0, 2'd0, 4'h4, 4'h0, 2'd0);
        n_checks++;
        if (out_abort !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_one_cycle: got ab=%b, required 0", out_abort);
        end
        chunk(1, 0, 0, 2'd0, 4'h5, 4'h0, 2'd0);
        chunk(1, 0, 1, 2'd0, 4'h6, 4'h2, 2'd1);
        n_checks++;
        if ({out_data, out_dec_valid, out_dec_success, out_frame_err, out_abort} !== {4'h4, 4'b1100}) begin
            n_errors++;
            $display("FAIL abort_next_frame: got data=%h dv=%b ok=%b fe=%b ab=%b, required 4 1 1 0 0",
                     out_data, out_dec_valid, out_dec_success, out_frame_err, out_abort);
        end
        // init+done while running: abort and single-chunk decision together
        chunk(1, 1, 0, 2'd1, 4'h0, 4'h0, 2'd0);
        chunk(1, 1, 1, 2'd1, 4'h0, 4'h0, 2'd1);
        n_checks++;
        if ({out_abort, out_dec_valid, out_dec_success, out_frame_err} !== 4'b1101) begin
            n_errors++;
            $display("FAIL abort_with_done: got ab=%b dv=%b ok=%b fe=%b, required 1 1 0 1",
                     out_abort, out_dec_valid, out_dec_success, out_frame_err);
        end
    endtask

    task automatic test_stall();
        chunk(0, 1, 1, 2'd3, 4'h9, 4'h0, 2'd3);
        n_checks++;
        if ({out_data_valid, out_dec_valid, out_abort} !== 3'b000) begin
            n_errors++;
            $display("FAIL stall_ignored_ctrl: got v=%b dv=%b ab=%b, required 0 0 0",
                     out_data_valid, out_dec_valid, out_abort);
        end
        chunk(1, 1, 0, 2'd0, 4'h7, 4'h0, 2'd0);
        chunk(0, 0, 1, 2'd0, 4'hE, 4'hF, 2'd1);
        n_checks++;
        if ({out_data, out_data_valid, out_first} !== {4'h7, 2'b00}) begin
            n_errors++;
            $display("FAIL stall_hold: got data=%h v=%b f=%b, required 7 0 0",
                     out_data, out_data_valid, out_first);
        end
        chunk(1, 0, 0, 2'd0, 4'h1, 4'h0, 2'd0);
        chunk(0, 0, 0, 2'd0, 4'hE, 4'h0, 2'd0);
        chunk(1, 0, 0, 2'd0, 4'h2, 4'h0, 2'd0);
        chunk(0, 0, 0, 2'd0, 4'hE, 4'h0, 2'd0);
        chunk(1, 0, 1, 2'd0, 4'h3, 4'h0, 2'd0);
        n_checks++;
        if ({out_data, out_last, out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err}
                !== {4'h3, 3'b111, 2'd0, 1'b0}) begin
            n_errors++;
            $display("FAIL stall_decision: got data=%h l=%b dv=%b ok=%b ec=%0d fe=%b, required 3 1 1 1 0 0",
                     out_data, out_last, out_dec_valid, out_dec_success, out_dec_errCnt, out_frame_err);
        end
        chunk(0, 0, 0, 2'd0, 4'h0, 4'h0, 2'd0);
        n_checks++;
        if ({out_last, out_dec_valid, out_dec_success, out_data} !== {3'b001, 4'h3}) begin
            n_errors++;
            $display("FAIL stall_pulse_width: got l=%b dv=%b ok=%b data=%h, required 0 0 1 3",
                     out_last, out_dec_valid, out_dec_success, out_data);
        end
    endtask

    task automatic test_single_and_idle();
        chunk(1, 1, 1, 2'd0, 4'h5, 4'h5, 2'd0);
        n_checks++;
        if ({out_data, out_first, out_last, out_dec_valid, out_dec_success, out_frame_err}
                !== {4'h0, 5'b11101}) begin
            n_errors++;
            $display("FAIL single_chunk: got data=%h f=%b l=%b dv=%b ok=%b fe=%b, required 0 1 1 1 0 1",
                     out_data, out_first, out_last, out_dec_valid, out_dec_success, out_frame_err);
        end
        chunk(1, 0, 1, 2'd0, 4'hC, 4'h0, 2'd3);
        n_checks++;
        if ({out_data_valid, out_dec_valid, out_dec_errCnt, out_data} !== {2'b00, 2'd0, 4'h0}) begin
            n_errors++;
            $display("FAIL idle_done_ignored: got v=%b dv=%b ec=%0d data=%h, required 0 0 0 0",
                     out_data_valid, out_dec_valid, out_dec_errCnt, out_data);
        end
    endtask

    task automatic test_reset_mid();
        chunk(1, 1, 0, 2'd2, 4'hD, 4'h0, 2'd0);
        chunk(1, 0, 0, 2'd0, 4'h6, 4'h0, 2'd0);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_data, out_data_valid, out_first, out_last, out_dec_valid, out_dec_success,
             out_dec_errCnt, out_frame_err, out_abort} !== 14'h0) begin
            n_errors++;
            $display("FAIL reset_mid_async: got data=%h v=%b ok=%b ec=%0d fe=%b, required all 0",
                     out_data, out_data_valid, out_dec_success, out_dec_errCnt, out_frame_err);
        end
        #2;
        rst_n = 1'b1;
        chunk(1, 0, 1, 2'd0, 4'hA, 4'h0, 2'd1);
        n_checks++;
        if ({out_data_valid, out_dec_valid, out_data} !== {2'b00, 4'h0}) begin
            n_errors++;
            $display("FAIL reset_mid_no_init: got v=%b dv=%b data=%h, required 0 0 0",
                     out_data_valid, out_dec_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_success();
        test_degree_mismatch();
        test_short_frame();
        test_long_frame();
        test_abort();
        test_stall();
        test_single_and_idle();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
